// File: rtl/pos_seq_pkg.sv
// Shared types and constants for the position-calculator sequencer.
// Holds the FSM state encoding, the pos_err codes and the default field widths.
package pos_seq_pkg;

    localparam int DW_DEF = 4;
    localparam int PW_DEF = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CHECK  = 3'd1,
        LAUNCH = 3'd2,
        WAIT   = 3'd3,
        RESULT = 3'd4
    } state_t;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_DEGEN   = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

endpackage

// File: rtl/sync_rise.sv
// Two-flop synchroniser for an asynchronous level, plus a one-cycle pulse
// on each synchronised low-to-high transition.
module sync_rise (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise_pulse
);

    // sync_r[0] may go metastable, sync_r[1] is the clean level, sync_r[2] its previous value
    logic [2:0] sync_r;

    // Shift the asynchronous level through the synchroniser chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= 3'b000;
        end else begin
            sync_r <= {sync_r[1:0], async_in};
        end
    end

    assign rise_pulse = sync_r[1] & ~sync_r[2];

endmodule

// File: rtl/pos_calc_sequencer.sv
// Control FSM for the acoustic position core: accepts a delay triplet, rejects
// degenerate geometry, launches the core and hands its result downstream.
// Optional feature macro: POS_SEQ_TIMEOUT_EN (completion timeout in WAIT).
module pos_calc_sequencer
    import pos_seq_pkg::*;
#(
    parameter int DW      = DW_DEF,
    parameter int PW      = PW_DEF,
    parameter int START_W = 2,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          dly_valid,
    output logic          dly_ready,
    input  logic [DW-1:0] dly12,
    input  logic [DW-1:0] dly13,
    input  logic [DW-1:0] dly14,
    output logic          core_ena,
    output logic [DW-1:0] core_d12,
    output logic [DW-1:0] core_d13,
    output logic [DW-1:0] core_d14,
    input  logic          core_end,
    input  logic [PW-1:0] core_x,
    input  logic [PW-1:0] core_y,
    input  logic [PW-1:0] core_z,
    output logic          pos_valid,
    input  logic          pos_ready,
    output logic [PW-1:0] pos_x,
    output logic [PW-1:0] pos_y,
    output logic [PW-1:0] pos_z,
    output logic [1:0]    pos_err,
    output logic          busy
);

    localparam int LW = (START_W > 1) ? $clog2(START_W) : 1;

    if (START_W < 1 || TIMEOUT < 4) begin : g_bad_param
        $error("pos_calc_sequencer: START_W must be >= 1 and TIMEOUT >= 4");
    end

    // d12 + d14 is formed one bit wider so a carry can never alias onto d13
    function automatic logic is_degenerate(input logic [DW-1:0] d12_v,
                                           input logic [DW-1:0] d13_v,
                                           input logic [DW-1:0] d14_v);
        logic [DW:0] sum_v;
        logic        all_zero_v;
        sum_v      = {1'b0, d12_v} + {1'b0, d14_v};
        all_zero_v = (d12_v == {DW{1'b0}}) && (d13_v == {DW{1'b0}}) && (d14_v == {DW{1'b0}});
        return (sum_v == {1'b0, d13_v}) || all_zero_v;
    endfunction

    state_t        state_r;
    state_t        state_s;
    logic          dly_ready_r;
    logic          core_ena_r;
    logic          pos_valid_r;
    logic          busy_r;
    logic [DW-1:0] core_d12_r;
    logic [DW-1:0] core_d13_r;
    logic [DW-1:0] core_d14_r;
    logic [PW-1:0] pos_x_r;
    logic [PW-1:0] pos_y_r;
    logic [PW-1:0] pos_z_r;
    logic [1:0]    pos_err_r;
    logic [LW-1:0] launch_cnt_r;
    logic          accept_s;
    logic          degen_s;
    logic          launch_done_s;
    logic          rise_s;
    logic          timeout_s;

    sync_rise u_end_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .async_in   (core_end),
        .rise_pulse (rise_s)
    );

    assign accept_s      = (state_r == IDLE) && dly_valid && dly_ready_r;
    assign degen_s       = is_degenerate(core_d12_r, core_d13_r, core_d14_r);
    assign launch_done_s = (launch_cnt_r == LW'(START_W - 1));

    // Count cycles spent in LAUNCH so core_ena lasts exactly START_W cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            launch_cnt_r <= {LW{1'b0}};
        end else if (state_r != LAUNCH) begin
            launch_cnt_r <= {LW{1'b0}};
        end else begin
            launch_cnt_r <= launch_cnt_r + LW'(1);
        end
    end

`ifdef POS_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] wait_cnt_r;

    // Wait counter is held at zero outside WAIT, so it starts from zero on entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_r <= {TW{1'b0}};
        end else if (state_r != WAIT) begin
            wait_cnt_r <= {TW{1'b0}};
        end else begin
            wait_cnt_r <= wait_cnt_r + TW'(1);
        end
    end

    // Fires as the count steps onto TIMEOUT, so RESULT is reached TIMEOUT cycles after entry
    assign timeout_s = (state_r == WAIT) && (wait_cnt_r == TW'(TIMEOUT - 1));
`else
    assign timeout_s = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; completion is tested before timeout so it wins a tie
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) state_s = CHECK;
                else          state_s = IDLE;
            end
            CHECK: begin
                if (degen_s) state_s = RESULT;
                else         state_s = LAUNCH;
            end
            LAUNCH: begin
                if (launch_done_s) state_s = WAIT;
                else               state_s = LAUNCH;
            end
            WAIT: begin
                if (rise_s)         state_s = RESULT;
                else if (timeout_s) state_s = RESULT;
                else                state_s = WAIT;
            end
            RESULT: begin
                if (pos_valid_r && pos_ready) state_s = IDLE;
                else                          state_s = RESULT;
            end
            default: state_s = IDLE;
        endcase
    end

    // Status and handshake outputs, registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dly_ready_r <= 1'b0;
            core_ena_r  <= 1'b0;
            pos_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            dly_ready_r <= (state_s == IDLE);
            core_ena_r  <= (state_s == LAUNCH);
            pos_valid_r <= (state_s == RESULT);
            busy_r      <= (state_s != IDLE);
        end
    end

    // Delays are captured on accept and held for the core until the next accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_d12_r <= {DW{1'b0}};
            core_d13_r <= {DW{1'b0}};
            core_d14_r <= {DW{1'b0}};
        end else if (accept_s) begin
            core_d12_r <= dly12;
            core_d13_r <= dly13;
            core_d14_r <= dly14;
        end
    end

    // Result capture: core values on completion, zeros with an error code otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_x_r   <= {PW{1'b0}};
            pos_y_r   <= {PW{1'b0}};
            pos_z_r   <= {PW{1'b0}};
            pos_err_r <= ERR_OK;
        end else if (state_r == CHECK && degen_s) begin
            pos_x_r   <= {PW{1'b0}};
            pos_y_r   <= {PW{1'b0}};
            pos_z_r   <= {PW{1'b0}};
            pos_err_r <= ERR_DEGEN;
        end else if (state_r == WAIT && rise_s) begin
            pos_x_r   <= core_x;
            pos_y_r   <= core_y;
            pos_z_r   <= core_z;
            pos_err_r <= ERR_OK;
        end else if (state_r == WAIT && timeout_s) begin
            pos_x_r   <= {PW{1'b0}};
            pos_y_r   <= {PW{1'b0}};
            pos_z_r   <= {PW{1'b0}};
            pos_err_r <= ERR_TIMEOUT;
        end
    end

    assign dly_ready = dly_ready_r;
    assign core_ena  = core_ena_r;
    assign core_d12  = core_d12_r;
    assign core_d13  = core_d13_r;
    assign core_d14  = core_d14_r;
    assign pos_valid = pos_valid_r;
    assign pos_x     = pos_x_r;
    assign pos_y     = pos_y_r;
    assign pos_z     = pos_z_r;
    assign pos_err   = pos_err_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_pos_calc_sequencer.sv
// Directed self-checking bench for pos_calc_sequencer with a procedural mock core.
// The timeout scenario follows POS_SEQ_TIMEOUT_EN when it is defined.
module tb_pos_calc_sequencer;

    localparam int DW      = 4;
    localparam int PW      = 16;
    localparam int START_W = 2;
    localparam int TIMEOUT = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          dly_valid;
    logic          dly_ready;
    logic [DW-1:0] dly12, dly13, dly14;
    logic          core_ena;
    logic [DW-1:0] core_d12, core_d13, core_d14;
    logic          core_end;
    logic [PW-1:0] core_x, core_y, core_z;
    logic          pos_valid;
    logic          pos_ready;
    logic [PW-1:0] pos_x, pos_y, pos_z;
    logic [1:0]    pos_err;
    logic          busy;

    int n_checks = 0;
    int n_pass   = 0;
    int bad_cnt;

    pos_calc_sequencer #(
        .DW(DW), .PW(PW), .START_W(START_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .dly_valid(dly_valid), .dly_ready(dly_ready),
        .dly12(dly12), .dly13(dly13), .dly14(dly14),
        .core_ena(core_ena),
        .core_d12(core_d12), .core_d13(core_d13), .core_d14(core_d14),
        .core_end(core_end),
        .core_x(core_x), .core_y(core_y), .core_z(core_z),
        .pos_valid(pos_valid), .pos_ready(pos_ready),
        .pos_x(pos_x), .pos_y(pos_y), .pos_z(pos_z),
        .pos_err(pos_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Advance n rising edges and settle 1 time unit past the last one
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] c);
        dly_valid = 1'b1;
        dly12 = a; dly13 = b; dly14 = c;
        tick(1);
        dly_valid = 1'b0;
    endtask

    task automatic handoff();
        pos_ready = 1'b1;
        tick(1);
        pos_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; dly_valid = 1'b0; pos_ready = 1'b0; core_end = 1'b0;
        dly12 = 4'd0; dly13 = 4'd0; dly14 = 4'd0;
        core_x = 16'd0; core_y = 16'd0; core_z = 16'd0;

        // Reset state
        tick(2);
        check("rst_dly_ready", 32'(dly_ready), 32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_core_ena",  32'(core_ena),  32'd0);
        check("rst_pos_valid", 32'(pos_valid), 32'd0);
        check("rst_pos_err",   32'(pos_err),   32'd0);
        rst_n = 1'b1;
        tick(1);
        check("rel_dly_ready", 32'(dly_ready), 32'd1);

        // Valid triplet 3,5,4 with mock core completing 10 cycles after launch
        offer(4'd3, 4'd5, 4'd4);
        check("t1_d12",  32'(core_d12), 32'd3);
        check("t1_d13",  32'(core_d13), 32'd5);
        check("t1_d14",  32'(core_d14), 32'd4);
        check("t1_busy", 32'(busy),     32'd1);
        check("t1_ena_c1", 32'(core_ena), 32'd0);
        tick(1); check("t1_ena_c2", 32'(core_ena), 32'd1);
        tick(1); check("t1_ena_c3", 32'(core_ena), 32'd1);
        tick(1); check("t1_ena_c4", 32'(core_ena), 32'd0);
        tick(8); check("t1_valid_c12", 32'(pos_valid), 32'd0);
        core_end = 1'b1; core_x = 16'd120; core_y = 16'd160; core_z = 16'd90;
        tick(2); check("t1_valid_c14", 32'(pos_valid), 32'd0);
        tick(1); check("t1_valid_c15", 32'(pos_valid), 32'd1);
        check("t1_x",   32'(pos_x),   32'd120);
        check("t1_y",   32'(pos_y),   32'd160);
        check("t1_z",   32'(pos_z),   32'd90);
        check("t1_err", 32'(pos_err), 32'd0);
        handoff();
        check("t1_valid_drop", 32'(pos_valid), 32'd0);
        check("t1_ready_back", 32'(dly_ready), 32'd1);
        core_end = 1'b0;
        tick(3);

        // Degenerate 2,5,3 held in RESULT while a second triplet is offered
        offer(4'd2, 4'd5, 4'd3);
        check("t2_valid_c1", 32'(pos_valid), 32'd0);
        tick(1);
        check("t2_valid_c2", 32'(pos_valid), 32'd1);
        check("t2_err",      32'(pos_err),   32'd1);
        check("t2_x_zero",   32'(pos_x),     32'd0);
        check("t2_z_zero",   32'(pos_z),     32'd0);
        check("t2_ena",      32'(core_ena),  32'd0);
        core_end = 1'b1;
        dly_valid = 1'b1; dly12 = 4'd1; dly13 = 4'd1; dly14 = 4'd1;
        bad_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            if (pos_valid !== 1'b1 || pos_err !== 2'b01 || dly_ready !== 1'b0 ||
                core_d12 !== 4'd2 || core_ena !== 1'b0 || pos_x !== 16'd0) bad_cnt++;
        end
        check("t4_hold_stable", 32'(bad_cnt), 32'd0);
        handoff();
        check("t4_valid_drop",  32'(pos_valid), 32'd0);
        check("t4_not_yet_acc", 32'(core_d12),  32'd2);
        tick(1);
        dly_valid = 1'b0;
        check("t4_accepted_d12", 32'(core_d12), 32'd1);
        check("t4_accepted_busy", 32'(busy), 32'd1);

        // Stale core_end level before launch must not complete the wait
        tick(3);
        check("t5_wait_ena", 32'(core_ena), 32'd0);
        tick(6);
        check("t5_stale_ignored", 32'(pos_valid), 32'd0);
        core_end = 1'b0;
        tick(3);
        core_end = 1'b1; core_x = 16'd7; core_y = 16'd8; core_z = 16'd9;
        tick(2); check("t5_valid_early", 32'(pos_valid), 32'd0);
        tick(1); check("t5_valid", 32'(pos_valid), 32'd1);
        check("t5_x",   32'(pos_x),   32'd7);
        check("t5_err", 32'(pos_err), 32'd0);
        handoff();
        core_end = 1'b0;
        tick(3);

        // All-zero triplet is degenerate
        offer(4'd0, 4'd0, 4'd0);
        tick(1);
        check("t7_valid", 32'(pos_valid), 32'd1);
        check("t7_err",   32'(pos_err),   32'd1);
        check("t7_x",     32'(pos_x),     32'd0);
        check("t7_ena",   32'(core_ena),  32'd0);
        handoff();

        // 15+15 = 30 must not alias onto 14
        offer(4'd15, 4'd14, 4'd15);
        tick(1);
        check("t8_ena", 32'(core_ena), 32'd1);
        tick(2);
        core_end = 1'b1; core_x = 16'd11;
        tick(3);
        check("t8_valid", 32'(pos_valid), 32'd1);
        check("t8_x",     32'(pos_x),     32'd11);
        check("t8_err",   32'(pos_err),   32'd0);
        handoff();
        core_end = 1'b0;
        tick(3);

`ifdef POS_SEQ_TIMEOUT_EN
        // Core never completes: timeout after TIMEOUT cycles in WAIT
        offer(4'd6, 4'd2, 4'd1);
        tick(3);
        tick(15);
        check("t3_valid_early", 32'(pos_valid), 32'd0);
        tick(1);
        check("t3_valid", 32'(pos_valid), 32'd1);
        check("t3_err",   32'(pos_err),   32'd2);
        check("t3_x",     32'(pos_x),     32'd0);
        check("t3_y",     32'(pos_y),     32'd0);
        handoff();
        offer(4'd6, 4'd2, 4'd1);
        tick(6);
`else
        // Core never completes: without timeout the sequencer stays busy
        offer(4'd6, 4'd2, 4'd1);
        tick(3);
        bad_cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            tick(1);
            if (busy !== 1'b1 || pos_valid !== 1'b0) bad_cnt++;
        end
        check("t3_no_timeout", 32'(bad_cnt), 32'd0);
        check("t3_err",        32'(pos_err), 32'd0);
`endif

        // Reset mid-WAIT, then a late core_end edge after release
        check("t6_pre_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #2;
        check("t6_async_busy",  32'(busy),      32'd0);
        check("t6_async_ena",   32'(core_ena),  32'd0);
        check("t6_async_valid", 32'(pos_valid), 32'd0);
        check("t6_async_ready", 32'(dly_ready), 32'd0);
        check("t6_async_d12",   32'(core_d12),  32'd0);
        tick(2);
        rst_n = 1'b1;
        core_end = 1'b1; core_x = 16'd55;
        tick(1);
        check("t6_ready_rel", 32'(dly_ready), 32'd1);
        check("t6_busy_rel",  32'(busy),      32'd0);
        tick(5);
        check("t6_no_valid", 32'(pos_valid), 32'd0);
        check("t6_idle",     32'(busy),      32'd0);
        check("t6_x",        32'(pos_x),     32'd0);
        check("t6_err",      32'(pos_err),   32'd0);
        core_end = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pos_calc_sequencer.md
# pos_calc_sequencer

Control FSM that drives the acoustic position calculator core. It accepts one delay triplet (d12, d13, d14) per measurement from the TDOA front end and rejects geometrically degenerate triplets. For valid triplets it launches the core and waits for the core's asynchronous completion flag, then hands the captured x/y/z result downstream over a valid/ready handshake. It sits between the delay estimator and the display/UART output path; the core itself is instantiated beside it, not inside it.

## Interface
- DW, 4: delay field width (units of 0.1 ms)
- PW, 16: position field width (mm)
- START_W, 2: cycles `core_ena` is held high per launch (≥1)
- TIMEOUT, 255: max `clk` cycles to wait for core completion (≥4)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- dly_valid  in  1  delay triplet offered
- dly_ready  out  1  sequencer can accept a triplet
- dly12, dly13, dly14  in  DW each  measured delays
- core_ena  out  1  launch level to core (core triggers on its rising edge)
- core_d12, core_d13, core_d14  out  DW each  registered delays to core, stable from launch until next accept
- core_end  in  1  core completion flag, asynchronous to `clk`
- core_x, core_y, core_z  in  PW each  core results, valid once `core_end` rises
- pos_valid  out  1  result available
- pos_ready  in  1  downstream accepts result
- pos_x, pos_y, pos_z  out  PW each  captured result
- pos_err  out  2  00 ok, 01 degenerate, 10 timeout
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, CHECK, LAUNCH, WAIT, RESULT.
- IDLE: `dly_ready`=1. On `dly_valid & dly_ready`, register the three delays into `core_d*` and go to CHECK.
- CHECK (1 cycle): a triplet is degenerate when the (DW+1)-bit sum d12+d14 equals d13, or when all three delays are 0.
  - Degenerate: set `pos_err`=01, zero `pos_x/y/z`, go to RESULT. `core_ena` is never raised.
  - Otherwise: go to LAUNCH.
- LAUNCH: `core_ena`=1 for exactly START_W cycles, then it drops to 0 and the FSM enters WAIT. The wait counter clears on entry to WAIT.
- WAIT: `core_end` passes through a 2-flop synchroniser and a rising-edge detector.
  - Edges seen before WAIT is entered are ignored.
  - On a detected rise: capture `core_x/y/z` into `pos_x/y/z`, set `pos_err`=00, go to RESULT.
- RESULT: `pos_valid`=1 and `pos_x/y/z` and `pos_err` are held stable. When `pos_valid & pos_ready`, go to IDLE; `pos_valid` drops the next cycle.
- A new triplet is never accepted while a result is pending. There is no overlap between measurements.

## Timing
- Reset values: state IDLE, `dly_ready`=0 while `rst_n` is low and 1 from the first clock after release. All other outputs are 0, and the synchroniser flops and counter are 0.
- Valid-path latency: accept at cycle 0, CHECK at 1, `core_ena` high at cycles 2..1+START_W, WAIT from 2+START_W.
- Completion latency: `pos_valid` rises 3 cycles after the first `clk` edge that samples `core_end` high (2 sync flops + 1 capture).
- Degenerate path: `pos_valid` rises at cycle 2.
- If `core_end` rises in the same cycle the timeout fires, completion wins.
- `pos_ready` held high in RESULT gives a 1-cycle result handoff. IDLE can accept again the cycle after handoff.
- Asserting reset in any state aborts immediately:
  - `core_ena` and `pos_valid` drop asynchronously.
  - A late `core_end` edge after reset release is ignored, because the FSM is not in WAIT.

## Configuration
- POS_SEQ_TIMEOUT_EN defined:
  - WAIT has a counter of width clog2(TIMEOUT+1).
  - When the count reaches TIMEOUT without completion, set `pos_err`=10, zero `pos_x/y/z`, go to RESULT.
- Undefined: no counter is built, WAIT waits indefinitely, and `pos_err` is never 10.

## Structure
- Package `pos_seq_pkg` holds:
  - the state enum
  - the `pos_err` codes ERR_OK/ERR_DEGEN/ERR_TIMEOUT
  - default DW/PW constants
- One sub-module `sync_rise` handles the 2-flop synchroniser plus rising-edge pulse, with asynchronous active-low reset. Everything else lives in the top module.

## Test plan
- Delays 3,5,4 (3+4≠5). Mock core raises `core_end` 10 cycles after `core_ena` rises, with x=120, y=160, z=90. Required: `core_ena` high for 2 cycles, then `pos_valid`=1 with 120/160/90 and `pos_err`=00.
- Delays 2,5,3 (sum=5): `pos_err`=01 and `pos_valid` at cycle 2; `core_ena` stays 0 throughout.
- With POS_SEQ_TIMEOUT_EN and TIMEOUT=16, the core never completes. Required: `pos_valid` with `pos_err`=10 and zero outputs 16 cycles after WAIT entry. Without the macro, `busy` stays 1 for 1000 cycles.
- `pos_ready` held low for 5 cycles in RESULT. Required: outputs stable, `dly_ready`=0, and a second `dly_valid` is not accepted until the cycle after handoff.
- `core_end` already high before launch. Required: the sequencer waits for a fresh low→high transition in WAIT, not the stale level.
- `rst_n` pulsed low mid-WAIT, then `core_end` rises. Required: all outputs 0, state IDLE, no `pos_valid`, and `dly_ready`=1 one cycle after release.
